seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed driver for a NUM_DIGITS common-anode/cathode 7-segment display.
//   Latches a packed hex value, per-digit decimal points and per-digit blank masks on a
//   load strobe, then scans one digit at a time with a programmable dwell and dead-time.
//   Hex-to-segment decode and leading-zero blanking are built in.
//   Sits between the board-level display pins and the datapath that produces values.
// PARAMETERS
//   NUM_DIGITS     4     digits scanned, >=1
//   PRESCALE       1000  clk cycles per digit slot, >= DEADTIME+2
//   DEADTIME       2     cycles at slot start with all anodes inactive (anti-ghosting)
//   SEG_ACT_LOW    1     1: seg/dp pins active-low, 0: active-high
//   AN_ACT_LOW     1     1: an pins active-low, 0: active-high
// PORTS
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous active-low reset
//   load       in   1             capture value_in/dp_in/blank_in at this edge
//   value_in   in   4*NUM_DIGITS  nibble i = hex for digit i (digit 0 = least significant)
//   dp_in      in   NUM_DIGITS    bit i = decimal point on for digit i
//   blank_in   in   NUM_DIGITS    bit i = force digit i dark
//   lzb_en     in   1             leading-zero blanking enable (sampled every cycle)
//   seg        out  7             segments {a,b,c,d,e,f,g}, seg[6]=a .. seg[0]=g
//   dp         out  1             decimal-point pin
//   an         out  NUM_DIGITS    digit enables, one-hot when active
//   scan_tick  out  1             1-cycle pulse at start of every frame (digit 0 slot)
// BEHAVIOUR
// - Reset (async, rst_n=0): shadow value=0, dp=0, blank=all ones; prescaler=0; digit
//   index=0; seg/dp/an driven inactive level; scan_tick=0. Display stays dark until load.
// - Shadow regs: on rising edge with load=1 capture all three inputs; load has no
//   handshake, every assertion is accepted; back-to-back loads last-wins.
// - Prescaler counts 0..PRESCALE-1 then wraps to 0; on wrap digit index advances,
//   NUM_DIGITS-1 wraps to 0. Index and prescaler never stall; load does not reset them.
// - scan_tick=1 for exactly the cycle in which index=0 and prescaler=0 (registered).
// - All outputs registered from (shadow, index, prescaler, lzb_en): a change of any input
//   at edge k appears on pins after edge k+1 (load -> pins: 1 cycle after capture edge).
// - Dead-time: while prescaler < DEADTIME, an = all inactive; seg/dp still decoded.
//   Otherwise an = one-hot at current index, unless the digit is blanked -> all inactive.
// - Digit i is blanked if blank_shadow[i], or lzb_en=1 and i>0 and nibbles i..NUM_DIGITS-1
//   are all zero. Digit 0 is never LZ-blanked. Blanked digit: seg and dp inactive too.
// - Decode (segments lit, a..g): 0 abcdef, 1 bc, 2 abdeg, 3 abcdg, 4 bcfg, 5 acdfg,
//   6 acdefg, 7 abc, 8 abcdefg, 9 abcdfg, A abcefg, b cdefg, C adef, d bcdeg, E adefg,
//   F aefg. Lit = 0 on pin if SEG_ACT_LOW else 1; same for dp; AN_ACT_LOW likewise for an.
// - NUM_DIGITS=1: index constant 0, scan_tick pulses every PRESCALE cycles.
// - Reset mid-scan: outputs go inactive immediately (async), scan restarts at digit 0.
// - Widths: prescaler $clog2(PRESCALE), index $clog2(NUM_DIGITS) (min 1 bit); no overflow
//   beyond explicit wraps.
// TESTING (NUM_DIGITS=4, PRESCALE=8, DEADTIME=2, both ACT_LOW=1 unless noted)
// 1 Reset, no load, run 64 cycles -> an=4'b1111, seg=7'h7F, dp=1 throughout; no X.
// 2 load value=16'h1234, dp=4'b0100, blank=0 -> slot digit0 seg=7'b1001100 (4), an=1110;
//   digit2 seg=7'b0010010 (2), dp=0; an inactive first 2 cycles of each slot.
// 3 load 16'h0050, lzb_en=1 -> digits 3,2 an stay 1; digit1 shows 5, digit0 shows 0;
//   lzb_en=0 -> digit3/2 show 0 (seg=7'b0000001).
// 4 load 16'h0000, lzb_en=1 -> only digit0 lit showing 0; blank_in=4'b0001 -> all dark.
// 5 scan_tick: pulses once per 32 cycles, coincident with first digit0 slot cycle;
//   load asserted on a slot wrap -> new value visible next cycle, scan timing unchanged.
// 6 Assert rst_n=0 mid-slot of digit2 -> pins inactive same cycle; release -> dark until load,
//   then scan resumes at digit0. Repeat 2 with SEG_ACT_LOW=0/AN_ACT_LOW=0 -> inverted pins.

Source files
------------

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : Time-multiplexed driver for a NUM_DIGITS 7-segment display.
//               A load strobe captures a packed hex value, per-digit decimal
//               points and per-digit blank masks into shadow registers. A
//               free-running prescaler/digit index scans one digit per slot,
//               holding all anodes off for DEADTIME cycles at each slot start.
//               Hex decode and leading-zero blanking are built in. Every pin
//               is registered.
// Ports       : clk        - system clock, rising edge
//               rst_n      - asynchronous active-low reset
//               load       - capture value_in / dp_in / blank_in this edge
//               value_in   - nibble i = hex value of digit i (digit 0 = LSD)
//               dp_in      - bit i = decimal point lit on digit i
//               blank_in   - bit i = force digit i dark
//               lzb_en     - leading-zero blanking enable
//               seg        - segments {a,b,c,d,e,f,g}, seg[6]=a
//               dp         - decimal-point pin
//               an         - digit enables, one-hot when active
//               scan_tick  - one-cycle pulse at the start of each frame
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int PRESCALE    = 1000,
  parameter int DEADTIME    = 2,
  parameter int SEG_ACT_LOW = 1,
  parameter int AN_ACT_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    scan_tick
);

  localparam int PW = (PRESCALE > 1)   ? $clog2(PRESCALE)   : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PW-1:0] c_PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IW-1:0] c_IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [PW-1:0] c_DEAD     = PW'(DEADTIME);

  // XOR masks turning "lit" polarity into pin polarity.
  localparam logic          c_SEG_INV = (SEG_ACT_LOW != 0);
  localparam logic          c_AN_INV  = (AN_ACT_LOW != 0);
  localparam logic [6:0]    c_SEG_OFF = {7{c_SEG_INV}};
  localparam logic          c_DP_OFF  = c_SEG_INV;
  localparam logic [NUM_DIGITS-1:0] c_AN_OFF = {NUM_DIGITS{c_AN_INV}};

  // Shadow registers and scan state
  logic [4*NUM_DIGITS-1:0] r_val;
  logic [NUM_DIGITS-1:0]   r_dp;
  logic [NUM_DIGITS-1:0]   r_blank;
  logic                    r_lzb;
  logic [PW-1:0]           r_pre;
  logic [IW-1:0]           r_idx;

  // Output registers
  logic [6:0]              r_seg;
  logic                    r_dp_pin;
  logic [NUM_DIGITS-1:0]   r_an;
  logic                    r_tick;

  // Per-digit decode helpers
  logic [3:0]              w_nib [NUM_DIGITS];
  logic [NUM_DIGITS-1:0]   w_upper_zero;
  logic [NUM_DIGITS-1:0]   w_blank_vec;

  logic [3:0]              w_nib_sel;
  logic                    w_blank_sel;
  logic                    w_dp_sel;
  logic [6:0]              w_lit;
  logic [NUM_DIGITS-1:0]   w_onehot;
  logic [6:0]              w_seg_nxt;
  logic                    w_dp_nxt;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic                    w_tick_nxt;

  // w_upper_zero[i] = nibbles i..NUM_DIGITS-1 are all zero, built from the top
  // digit downwards so each digit reuses the result of the one above it.
  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    assign w_nib[gi] = r_val[4*gi +: 4];
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign w_upper_zero[gi] = (w_nib[gi] == 4'h0);
    end else begin : g_lower
      assign w_upper_zero[gi] = (w_nib[gi] == 4'h0) & w_upper_zero[gi+1];
    end
    if (gi == 0) begin : g_lsd
      // The least significant digit always shows, even when it is zero.
      assign w_blank_vec[gi] = r_blank[gi];
    end else begin : g_msd
      assign w_blank_vec[gi] = r_blank[gi] | (r_lzb & w_upper_zero[gi]);
    end
  end

  always_comb begin
    w_nib_sel   = w_nib[r_idx];
    w_blank_sel = w_blank_vec[r_idx];
    w_dp_sel    = r_dp[r_idx];
    w_onehot    = NUM_DIGITS'(1) << r_idx;

    // Segments lit, bit order {a,b,c,d,e,f,g}
    w_lit = 7'h00;
    case (w_nib_sel)
      4'h0: w_lit = 7'b1111110;
      4'h1: w_lit = 7'b0110000;
      4'h2: w_lit = 7'b1101101;
      4'h3: w_lit = 7'b1111001;
      4'h4: w_lit = 7'b0110011;
      4'h5: w_lit = 7'b1011011;
      4'h6: w_lit = 7'b1011111;
      4'h7: w_lit = 7'b1110000;
      4'h8: w_lit = 7'b1111111;
      4'h9: w_lit = 7'b1111011;
      4'hA: w_lit = 7'b1110111;
      4'hB: w_lit = 7'b0011111;
      4'hC: w_lit = 7'b1001110;
      4'hD: w_lit = 7'b0111101;
      4'hE: w_lit = 7'b1001111;
      4'hF: w_lit = 7'b1000111;
      default: w_lit = 7'h00;
    endcase

    // Segments keep decoding through the dead-time so they have settled
    // before the anode turns on; only the anode is gated by dead-time.
    w_seg_nxt = w_blank_sel ? c_SEG_OFF : (w_lit ^ c_SEG_OFF);
    w_dp_nxt  = w_blank_sel ? c_DP_OFF  : (w_dp_sel ^ c_DP_OFF);
    w_an_nxt  = ((r_pre < c_DEAD) || w_blank_sel) ? c_AN_OFF
                                                  : (w_onehot ^ c_AN_OFF);
    w_tick_nxt = (r_idx == '0) && (r_pre == '0);
  end

  // Shadow capture; last load wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val   <= '0;
      r_dp    <= '0;
      r_blank <= '1;
      r_lzb   <= 1'b0;
    end else begin
      r_lzb <= lzb_en;
      if (load) begin
        r_val   <= value_in;
        r_dp    <= dp_in;
        r_blank <= blank_in;
      end
    end
  end

  // Free-running scan counters; never stalled or reset by load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else if (r_pre == c_PRE_LAST) begin
      r_pre <= '0;
      r_idx <= (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg    <= c_SEG_OFF;
      r_dp_pin <= c_DP_OFF;
      r_an     <= c_AN_OFF;
      r_tick   <= 1'b0;
    end else begin
      r_seg    <= w_seg_nxt;
      r_dp_pin <= w_dp_nxt;
      r_an     <= w_an_nxt;
      r_tick   <= w_tick_nxt;
    end
  end

  assign seg       = r_seg;
  assign dp        = r_dp_pin;
  assign an        = r_an;
  assign scan_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Scoreboard bench for seg7_scan_driver. Two instances share the
//               stimulus: one with active-low pins, one with active-high pins.
//               Expected pin states are queued with the clock edge after which
//               they must appear; a monitor pops and compares on falling edges.
//               Edge numbering: edge 1 is the first rising edge after reset
//               release; after edge e the pins reflect slot state e-1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [3:0]  blank_in;
  logic        lzb_en;

  logic [6:0]  seg,   seg_h;
  logic        dp,    dp_h;
  logic [3:0]  an,    an_h;
  logic        tick,  tick_h;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(8), .DEADTIME(2),
                     .SEG_ACT_LOW(1), .AN_ACT_LOW(1)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .lzb_en(lzb_en),
    .seg(seg), .dp(dp), .an(an), .scan_tick(tick));

  seg7_scan_driver #(.NUM_DIGITS(4), .PRESCALE(8), .DEADTIME(2),
                     .SEG_ACT_LOW(0), .AN_ACT_LOW(0)) dut_h (
    .clk(clk), .rst_n(rst_n), .load(load), .value_in(value_in),
    .dp_in(dp_in), .blank_in(blank_in), .lzb_en(lzb_en),
    .seg(seg_h), .dp(dp_h), .an(an_h), .scan_tick(tick_h));

  typedef struct {
    int         e;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    string      name;
  } exp_t;

  exp_t q[$];
  exp_t m_x;
  int   cyc;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Expected values are given for the active-low instance; the active-high
  // instance must show the bitwise complement on every pin.
  task automatic check(string name, logic [3:0] an_e, logic [6:0] seg_e,
                       logic dp_e, logic tick_e);
    n_vec++;
    if (an !== an_e || seg !== seg_e || dp !== dp_e || tick !== tick_e ||
        an_h !== ~an_e || seg_h !== ~seg_e || dp_h !== ~dp_e || tick_h !== tick_e) begin
      n_bad++;
      $display("FAIL %s @edge %0d: lo an=%b seg=%b dp=%b tick=%b | hi an=%b seg=%b dp=%b tick=%b | required lo an=%b seg=%b dp=%b tick=%b (hi inverted)",
               name, cyc, an, seg, dp, tick, an_h, seg_h, dp_h, tick_h,
               an_e, seg_e, dp_e, tick_e);
    end
  endtask

  task automatic push(int e, logic [3:0] an_e, logic [6:0] seg_e,
                      logic dp_e, logic tick_e, string name);
    exp_t x;
    x.e = e; x.an = an_e; x.seg = seg_e; x.dp = dp_e; x.tick = tick_e; x.name = name;
    q.push_back(x);
  endtask

  // Monitor: entries whose edge has been passed without being seen count as misses.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].e <= cyc && rst_n) begin
      m_x = q.pop_front();
      if (m_x.e < cyc) begin
        n_vec++;
        n_bad++;
        $display("FAIL %s missed: edge %0d required, now %0d", m_x.name, m_x.e, cyc);
      end else begin
        check(m_x.name, m_x.an, m_x.seg, m_x.dp, m_x.tick);
      end
    end
  end

  task automatic goto(int c);
    int g = 0;
    while (cyc < c && g < 1000) begin
      @(negedge clk);
      g++;
    end
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b0; value_in = '0; dp_in = '0; blank_in = '0; lzb_en = 1'b0;
    repeat (3) @(negedge clk);

    // 1: no load after reset -> dark, ticks at edges 1 and 33
    for (int e = 1; e <= 64; e++)
      push(e, 4'hF, 7'h7F, 1'b1, ((e - 1) % 32) == 0, "t1_dark");
    // 2: 1234, dp on digit 2
    push(66, 4'hF, 7'b1001100, 1'b1, 1'b0, "t2_d0_dead");
    push(67, 4'hE, 7'b1001100, 1'b1, 1'b0, "t2_d0");
    push(73, 4'hF, 7'b0000110, 1'b1, 1'b0, "t2_d1_dead");
    push(75, 4'hD, 7'b0000110, 1'b1, 1'b0, "t2_d1");
    push(81, 4'hF, 7'b0010010, 1'b0, 1'b0, "t2_d2_dead_dp");
    push(82, 4'hF, 7'b0010010, 1'b0, 1'b0, "t2_d2_dead2");
    push(83, 4'hB, 7'b0010010, 1'b0, 1'b0, "t2_d2");
    push(88, 4'hB, 7'b0010010, 1'b0, 1'b0, "t2_d2_last");
    push(89, 4'hF, 7'b1001111, 1'b1, 1'b0, "t2_d3_dead");
    push(91, 4'h7, 7'b1001111, 1'b1, 1'b0, "t2_d3");
    push(96, 4'h7, 7'b1001111, 1'b1, 1'b0, "t2_pretick");
    push(97, 4'hF, 7'b1001100, 1'b1, 1'b1, "t2_tick");
    // 3: 0050 with and without leading-zero blanking
    push(131, 4'hE, 7'b0000001, 1'b1, 1'b0, "t3_lzb_d0");
    push(139, 4'hD, 7'b0100100, 1'b1, 1'b0, "t3_lzb_d1");
    push(147, 4'hF, 7'h7F,      1'b1, 1'b0, "t3_lzb_d2");
    push(155, 4'hF, 7'h7F,      1'b1, 1'b0, "t3_lzb_d3");
    push(179, 4'hB, 7'b0000001, 1'b1, 1'b0, "t3_nolzb_d2");
    push(188, 4'h7, 7'b0000001, 1'b1, 1'b0, "t3_nolzb_d3");
    // 4: all zero with lzb, then blank digit 0 too
    push(195, 4'hE, 7'b0000001, 1'b1, 1'b0, "t4_zero_d0");
    push(203, 4'hF, 7'h7F,      1'b1, 1'b0, "t4_zero_d1");
    push(219, 4'hF, 7'h7F,      1'b1, 1'b0, "t4_zero_d3");
    push(225, 4'hF, 7'b0000001, 1'b1, 1'b1, "t4_tick_old");
    push(227, 4'hF, 7'h7F,      1'b1, 1'b0, "t4_all_dark");
    push(228, 4'hF, 7'h7F,      1'b1, 1'b0, "t4_all_dark2");
    // 5: ABCD loaded on the d0->d1 wrap edge
    push(264, 4'hF, 7'h7F,      1'b1, 1'b0, "t5_before");
    push(265, 4'hF, 7'b0110001, 1'b0, 1'b0, "t5_next_cycle");
    push(267, 4'hD, 7'b0110001, 1'b0, 1'b0, "t5_d1");
    push(281, 4'hF, 7'b0001000, 1'b0, 1'b0, "t5_d3_dead");
    push(288, 4'h7, 7'b0001000, 1'b0, 1'b0, "t5_d3_last");
    push(289, 4'hF, 7'b1000010, 1'b0, 1'b1, "t5_tick");
    push(291, 4'hE, 7'b1000010, 1'b0, 1'b0, "t5_d0");
    // 6: digit 2 lit just before the reset
    push(308, 4'hB, 7'b1100000, 1'b0, 1'b0, "t6_pre_reset");

    rst_n = 1'b1;

    goto(64);  value_in = 16'h1234; dp_in = 4'b0100; blank_in = 4'b0000; load = 1'b1;
    goto(65);  load = 1'b0;
    goto(100); value_in = 16'h0050; dp_in = 4'b0000; lzb_en = 1'b1; load = 1'b1;
    goto(101); load = 1'b0;
    goto(160); lzb_en = 1'b0;
    goto(192); value_in = 16'h0000; lzb_en = 1'b1; load = 1'b1;
    goto(193); load = 1'b0;
    goto(224); blank_in = 4'b0001; load = 1'b1;
    goto(225); load = 1'b0;
    goto(263); value_in = 16'hABCD; dp_in = 4'b1111; blank_in = 4'b0000;
               lzb_en = 1'b0; load = 1'b1;
    goto(264); load = 1'b0;
    goto(309);

    // Asynchronous reset in the middle of the digit-2 slot
    #2 rst_n = 1'b0;
    #1 check("t6_async_reset", 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    check("t6_in_reset", 4'hF, 7'h7F, 1'b1, 1'b0);

    for (int e = 1; e <= 8; e++)
      push(e, 4'hF, 7'h7F, 1'b1, e == 1, "t6_dark");
    push(10, 4'hF, 7'b0000110, 1'b1, 1'b0, "t6_reload_d1_dead");
    push(11, 4'hD, 7'b0000110, 1'b1, 1'b0, "t6_reload_d1");
    push(33, 4'hF, 7'b1001100, 1'b1, 1'b1, "t6_tick");
    push(35, 4'hE, 7'b1001100, 1'b1, 1'b0, "t6_d0");
    value_in = 16'h1234; dp_in = 4'b0100; blank_in = 4'b0000;
    rst_n = 1'b1;

    goto(8); load = 1'b1;
    goto(9); load = 1'b0;

    begin
      int g = 0;
      while (q.size() > 0 && g < 200) begin
        @(negedge clk);
        g++;
      end
    end
    if (q.size() > 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: %0d entries left, required 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
